game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
- Central round sequencer for the LED memory game.
- Owns the per-round flow: pattern_generator → print_pattern → input_trim → compare/score → inter-round gap → next round.
- Counts rounds and correct answers, computes the score fed to print_score_7seg, and drives the round-local reset that clears the sub-blocks between rounds.
- Runs on the 1 kHz game clock.

Parameters:
- NUM_ROUNDS, 10, rounds per game (1..31).
- PTS_PER_WIN, 10, score points per won round.
- SETTLE_CYC, 4, cycles waited after inp_done before sampling round_win (lets trimmed inputs settle).
- RST_CYC, 2, cycles sub_rst is held high at the start of each gap.
- GAP_CYC, 500, total inter-round gap cycles (≥ RST_CYC+1).
- TIMEOUT_CYC, 5000, input timeout cycles (used only with the optional feature).

Ports:
- clk  in  1  game clock (1 kHz)
- rst  in  1  synchronous, active-high reset
- level_valid  in  1  level selected, held high (from level_select end_signal)
- gen_done  in  1  pattern ready, level signal (pattern_gen_end)
- show_done  in  1  LED playback finished, level signal (print_pattern_end)
- inp_done  in  1  all inputs captured, level signal (input_trim_end)
- round_win  in  1  combinational compare of trimmed inputs vs pattern
- gen_start  out  1  one-cycle pulse: generate a new pattern
- show_en  out  1  enable for print_pattern
- inp_en  out  1  enable for input_trim
- sub_rst  out  1  active-high round reset to generator/printer/trimmer
- round_count  out  5  completed rounds
- answer_count  out  5  won rounds
- score  out  7  PTS_PER_WIN*answer_count, saturates at 127
- game_over  out  1  high in DONE
- state  out  3  current FSM state (debug)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; all counts, score and strobes 0; sub_rst=1 while rst is high. Reset wins over every other event, in any state.
- State encoding: IDLE=0, GEN=1, SHOW=2, INPUT=3, SETTLE=4, SCORE=5, GAP=6, DONE=7.
- IDLE: sub_rst=1. level_valid is sampled only here. When it is 1, go to GEN next cycle.
- GEN: gen_start=1 on the first GEN cycle only. Wait until gen_done=1 with gen_start already issued, then go to SHOW. A gen_done already high on GEN entry is ignored until after the pulse.
- SHOW: show_en=1. show_done=1 → INPUT.
- INPUT: inp_en=1. inp_done=1 → SETTLE, settle counter cleared.
- SETTLE: inp_en stays 1. Count SETTLE_CYC cycles, then latch round_win into win_q and go to SCORE.
- SCORE: single cycle.
  - round_count += 1.
  - answer_count += win_q.
  - score register updates the following cycle.
  - Next state: GAP, gap counter cleared.
- GAP:
  - sub_rst=1 for gap cycles 0..RST_CYC-1, then 0.
  - After GAP_CYC cycles: if round_count == NUM_ROUNDS → DONE, else → GEN.
- DONE: game_over=1, sub_rst=1. Counts and score frozen. Only rst exits.
- Output timing: all outputs are registered. gen_start, show_en and inp_en are Moore outputs, valid one cycle after the state transition.
- Arithmetic:
  - Counters are unsigned.
  - score = answer_count*PTS_PER_WIN, clamped to 127.
  - answer_count can never exceed round_count.
- Boundary: level_valid dropping after IDLE is ignored. The game continues until DONE or rst.

Optional Feature:
- Macro: ROUND_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in INPUT.
  - On reaching TIMEOUT_CYC with inp_done=0, go directly to SCORE with win_q forced to 0 (round lost).
  - If inp_done and timeout occur in the same cycle, inp_done wins (→ SETTLE).
- Undefined: INPUT waits indefinitely; no timeout counter is synthesized.

Test Plan (SETTLE_CYC=4, RST_CYC=2, GAP_CYC=8, NUM_ROUNDS=3):
- Reset, then level_valid=1 → gen_start is high for exactly 1 cycle, 2 cycles after level_valid; state=1.
- Three rounds with round_win=1,0,1 (done signals asserted promptly) → round_count=3, answer_count=2, score=20, game_over=1, state=7.
- GAP observation → sub_rst is high for exactly 2 cycles, then low for 6; the next gen_start follows the 8th gap cycle.
- round_win toggles during SETTLE, ending at 1 on the 4th cycle → that round is counted as won (sampled only at the end of SETTLE).
- rst asserted mid-SHOW in round 2 → next cycle: state=0, round_count=0, score=0, show_en=0, sub_rst=1.
- With ROUND_TIMEOUT_EN and TIMEOUT_CYC=20: inp_done is never asserted → SCORE after 20 INPUT cycles, round counted as lost, answer_count unchanged.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Round sequencer for the LED memory game: generate -> show -> input -> settle -> score -> gap.
// Optional input timeout enabled by defining ROUND_TIMEOUT_EN.
module game_round_ctrl #(
   parameter int unsigned NUM_ROUNDS  = 10,
   parameter int unsigned PTS_PER_WIN = 10,
   parameter int unsigned SETTLE_CYC  = 4,
   parameter int unsigned RST_CYC     = 2,
   parameter int unsigned GAP_CYC     = 500,
   parameter int unsigned TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       level_valid,
   input  logic       gen_done,
   input  logic       show_done,
   input  logic       inp_done,
   input  logic       round_win,
   output logic       gen_start,
   output logic       show_en,
   output logic       inp_en,
   output logic       sub_rst,
   output logic [4:0] round_count,
   output logic [4:0] answer_count,
   output logic [6:0] score,
   output logic       game_over,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_SHOW   = 3'd2,
      S_INPUT  = 3'd3,
      S_SETTLE = 3'd4,
      S_SCORE  = 3'd5,
      S_GAP    = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31 || SETTLE_CYC < 1 ||
       GAP_CYC < RST_CYC + 1 || TIMEOUT_CYC < 1) begin : g_bad_params
      $error("game_round_ctrl: parameter out of range");
   end

   state_t           st;
   logic [SET_W-1:0] settle_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             gen_issued;
   logic             win_q;
   logic [15:0]      prod;
   logic [6:0]       score_next;

`ifdef ROUND_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
`endif

   always_comb begin
      prod       = 16'(answer_count) * 16'(PTS_PER_WIN);
      score_next = (prod > 16'd127) ? 7'd127 : prod[6:0];
   end

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= S_IDLE;
         settle_cnt   <= '0;
         gap_cnt      <= '0;
         gen_issued   <= 1'b0;
         win_q        <= 1'b0;
         round_count  <= '0;
         answer_count <= '0;
         score        <= '0;
         gen_start    <= 1'b0;
         show_en      <= 1'b0;
         inp_en       <= 1'b0;
         sub_rst      <= 1'b1;
         game_over    <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
         to_cnt       <= '0;
`endif
      end else begin
         // Moore outputs are registered from the current state, so they trail it by one cycle
         gen_start <= (st == S_GEN) && !gen_issued;
         show_en   <= (st == S_SHOW);
         inp_en    <= (st == S_INPUT) || (st == S_SETTLE);
         sub_rst   <= (st == S_IDLE) || (st == S_DONE) ||
                      ((st == S_GAP) && (gap_cnt < GAP_W'(RST_CYC)));
         game_over <= (st == S_DONE);
         score     <= score_next;

         case (st)
            S_IDLE: begin
               if (level_valid) begin
                  st         <= S_GEN;
                  gen_issued <= 1'b0;
               end
            end
            S_GEN: begin
               // gen_done is only honoured once the start pulse has gone out
               if (!gen_issued) gen_issued <= 1'b1;
               else if (gen_done) st <= S_SHOW;
            end
            S_SHOW: begin
               if (show_done) begin
                  st <= S_INPUT;
`ifdef ROUND_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end
            end
            S_INPUT: begin
               if (inp_done) begin
                  st         <= S_SETTLE;
                  settle_cnt <= '0;
               end
`ifdef ROUND_TIMEOUT_EN
               else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  st    <= S_SCORE;
                  win_q <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            S_SETTLE: begin
               if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                  win_q <= round_win;
                  st    <= S_SCORE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            S_SCORE: begin
               round_count  <= round_count + 5'd1;
               answer_count <= answer_count + {4'b0000, win_q};
               gap_cnt      <= '0;
               st           <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                  st         <= (round_count == 5'(NUM_ROUNDS)) ? S_DONE : S_GEN;
                  gen_issued <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            S_DONE: begin
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: cycle model of the round rules plus directed literal checks.
module tb_game_round_ctrl;

   localparam int N_R  = 3;
   localparam int PTS  = 10;
   localparam int SET  = 4;
   localparam int RSTC = 2;
   localparam int GAP  = 8;
   localparam int TO   = 20;
`ifdef ROUND_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, level_valid, gen_done, show_done, inp_done, round_win;
   logic       gen_start, show_en, inp_en, sub_rst, game_over;
   logic [4:0] round_count, answer_count;
   logic [6:0] score;
   logic [2:0] state;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   game_round_ctrl #(
      .NUM_ROUNDS(N_R), .PTS_PER_WIN(PTS), .SETTLE_CYC(SET),
      .RST_CYC(RSTC), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst), .level_valid(level_valid), .gen_done(gen_done),
      .show_done(show_done), .inp_done(inp_done), .round_win(round_win),
      .gen_start(gen_start), .show_en(show_en), .inp_en(inp_en), .sub_rst(sub_rst),
      .round_count(round_count), .answer_count(answer_count), .score(score),
      .game_over(game_over), .state(state)
   );

   always #5 clk = ~clk;

   // Model: phase number plus cycles spent in that phase; outputs derived from the rules
   int m_phase = 0, m_elapsed = 0, m_rounds = 0, m_wins = 0, m_pending = 0;
   bit e_gen, e_show, e_inp, e_sub, e_over;
   int e_score;

   always @(posedge clk) begin
      int nxt;
      if (rst) begin
         {e_gen, e_show, e_inp, e_over} = 4'b0;
         e_sub = 1'b1;
         e_score = 0;
         m_phase = 0; m_elapsed = 0; m_rounds = 0; m_wins = 0; m_pending = 0;
      end else begin
         e_gen   = (m_phase == 1) && (m_elapsed == 0);
         e_show  = (m_phase == 2);
         e_inp   = (m_phase == 3) || (m_phase == 4);
         e_sub   = (m_phase == 0) || (m_phase == 7) || (m_phase == 6 && m_elapsed < RSTC);
         e_over  = (m_phase == 7);
         e_score = (m_wins * PTS > 127) ? 127 : m_wins * PTS;
         nxt = m_phase;
         case (m_phase)
            0: if (level_valid) nxt = 1;
            1: if (m_elapsed >= 1 && gen_done) nxt = 2;
            2: if (show_done) nxt = 3;
            3: if (inp_done) nxt = 4;
               else if (TO_EN && m_elapsed == TO - 1) begin nxt = 5; m_pending = 0; end
            4: if (m_elapsed == SET - 1) begin nxt = 5; m_pending = int'(round_win); end
            5: begin m_rounds++; m_wins += m_pending; nxt = 6; end
            6: if (m_elapsed == GAP - 1) nxt = (m_rounds == N_R) ? 7 : 1;
            default: nxt = m_phase;
         endcase
         m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
         m_phase = nxt;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (state !== 3'(m_phase) || gen_start !== e_gen || show_en !== e_show ||
             inp_en !== e_inp || sub_rst !== e_sub || game_over !== e_over ||
             round_count !== 5'(m_rounds) || answer_count !== 5'(m_wins) ||
             score !== 7'(e_score)) begin
            fails++;
            $display("FAIL cycle_model t=%0t got st=%0d gs=%b sh=%b in=%b sr=%b go=%b rc=%0d ac=%0d sc=%0d required st=%0d gs=%b sh=%b in=%b sr=%b go=%b rc=%0d ac=%0d sc=%0d",
                     $time, state, gen_start, show_en, inp_en, sub_rst, game_over,
                     round_count, answer_count, score, m_phase, e_gen, e_show, e_inp,
                     e_sub, e_over, m_rounds, m_wins, e_score);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d required=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_state_%0d", s), 32'(state), 32'(s));
   endtask

   initial begin
      logic [7:0] pat;
      int n;
      rst = 1'b1; level_valid = 1'b0; gen_done = 1'b0; show_done = 1'b0;
      inp_done = 1'b0; round_win = 1'b0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("reset_state", 32'(state), 0);
      check("reset_sub_rst", 32'(sub_rst), 1);
      check("reset_counts", {22'b0, round_count, answer_count}, 0);
      check("reset_score", 32'(score), 0);

      // Game 1: rounds won/lost/won
      rst = 1'b0; level_valid = 1'b1; gen_done = 1'b1; show_done = 1'b1;
      tick(1);
      check("gen_entry_state", 32'(state), 1);
      check("gen_start_before", 32'(gen_start), 0);
      tick(1);
      check("gen_start_pulse", 32'(gen_start), 1);
      level_valid = 1'b0;
      tick(1);
      check("gen_start_after", 32'(gen_start), 0);

      wait_state(3, 20);
      round_win = 1'b1; inp_done = 1'b1;
      wait_state(6, 20);
      inp_done = 1'b0;
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         pat = {pat[6:0], sub_rst};
      end
      check("gap_sub_rst_pattern", 32'(pat), 32'hC0);
      check("gap_exit_state", 32'(state), 1);
      tick(1);
      check("gap_next_gen_start", 32'(gen_start), 1);

      round_win = 1'b0;
      wait_state(3, 20);
      inp_done = 1'b1;
      wait_state(6, 20);
      inp_done = 1'b0;

      wait_state(3, 40);
      inp_done = 1'b1; round_win = 1'b0;
      wait_state(4, 10);
      inp_done = 1'b0;
      tick(1); round_win = 1'b1;
      tick(1); round_win = 1'b0;
      tick(1); round_win = 1'b1;
      wait_state(6, 10);
      check("settle_last_sample_wins", 32'(answer_count), 2);

      wait_state(7, 40);
      tick(2);
      check("done_round_count", 32'(round_count), 3);
      check("done_answer_count", 32'(answer_count), 2);
      check("done_score", 32'(score), 20);
      check("done_game_over", 32'(game_over), 1);
      level_valid = 1'b1; round_win = 1'b0; inp_done = 1'b1;
      tick(5);
      check("done_frozen_state", 32'(state), 7);
      check("done_frozen_score", 32'(score), 20);

      // Game 2: reset in the middle of round 2's playback
      rst = 1'b1; tick(1); rst = 1'b0;
      round_win = 1'b1;
      wait_state(6, 30);
      show_done = 1'b0; level_valid = 1'b0;
      wait_state(2, 30);
      tick(1);
      check("pre_rst_score", 32'(score), 10);
      rst = 1'b1;
      tick(1);
      check("midshow_rst_state", 32'(state), 0);
      check("midshow_rst_round_count", 32'(round_count), 0);
      check("midshow_rst_score", 32'(score), 0);
      check("midshow_rst_show_en", 32'(show_en), 0);
      check("midshow_rst_sub_rst", 32'(sub_rst), 1);

`ifdef ROUND_TIMEOUT_EN
      // Game 3: win round 1, then let round 2 input time out with round_win held high
      tick(1);
      rst = 1'b0; level_valid = 1'b1; show_done = 1'b1; inp_done = 1'b1; round_win = 1'b1;
      wait_state(6, 30);
      inp_done = 1'b0;
      wait_state(3, 40);
      n = 0;
      while (state === 3'd3 && n < 100) begin
         tick(1);
         n++;
      end
      check("timeout_input_cycles", 32'(n), 20);
      check("timeout_to_score", 32'(state), 5);
      tick(1);
      check("timeout_round_count", 32'(round_count), 2);
      check("timeout_answer_unchanged", 32'(answer_count), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
